// File: rtl/axis_arb_pkg.sv
// Shared types and helpers for the packet-level round-robin AXI-Stream arbiter.
// Port counts up to MAX_PORTS are handled by the helpers; widths stay module parameters.
package axis_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    localparam int MAX_PORTS = 8;

    // Index width for n requesters, never below one bit.
    function automatic int sel_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // First requester found scanning last+1, last+2, ... modulo n; returns last when nothing requests.
    function automatic logic [2:0] rr_winner(
        input logic [MAX_PORTS-1:0] req,
        input logic [2:0]           last,
        input int                   n
    );
        logic [2:0] win;
        int         idx;
        win = last;
        // Walk the scan order backwards so the earliest requester is written last.
        for (int k = MAX_PORTS; k >= 1; k--) begin
            if (k <= n) begin
                idx = (int'(last) + k) % n;
                if (req[idx[2:0]]) begin
                    win = idx[2:0];
                end
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/axis_rr_pick.sv
// Combinational rotating-priority selector: lowest scan distance from last_grant wins.
module axis_rr_pick
    import axis_arb_pkg::*;
#(
    parameter int NUM_PORTS = 4,
    parameter int SEL_W     = $clog2(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [SEL_W-1:0]     last_grant,
    output logic [SEL_W-1:0]     winner,
    output logic                 any_req
);

    logic [MAX_PORTS-1:0] req_ext;

    // Unused upper request lanes are tied low so the shared helper sees a full-width vector.
    genvar gi;
    generate
        for (gi = 0; gi < MAX_PORTS; gi++) begin : g_req_ext
            if (gi < NUM_PORTS) begin : g_live
                assign req_ext[gi] = req[gi];
            end else begin : g_tie
                assign req_ext[gi] = 1'b0;
            end
        end
    endgenerate

    always_comb begin
        winner  = SEL_W'(rr_winner(req_ext, 3'(last_grant), NUM_PORTS));
        any_req = |req;
    end

endmodule

// File: rtl/axis_rr_arbiter.sv
// Packet-level round-robin arbiter: NUM_PORTS AXI-Stream slaves onto one registered master.
// A grant is held from the first beat until the granted port's tlast beat is accepted.
module axis_rr_arbiter
    import axis_arb_pkg::*;
#(
    parameter  int AXIS_DATA_WIDTH  = 512,
    parameter  int AXIS_TUSER_WIDTH = 256,
    parameter  int NUM_PORTS        = 4,
    localparam int SEL_W            = $clog2(NUM_PORTS),
    localparam int KEEP_W           = AXIS_DATA_WIDTH / 8
) (
    input  logic                                  axis_aclk,
    input  logic                                  axis_reset,

    input  logic [NUM_PORTS*AXIS_DATA_WIDTH-1:0]  s_axis_tdata,
    input  logic [NUM_PORTS*KEEP_W-1:0]           s_axis_tkeep,
    input  logic [NUM_PORTS*AXIS_TUSER_WIDTH-1:0] s_axis_tuser,
    input  logic [NUM_PORTS-1:0]                  s_axis_tvalid,
    input  logic [NUM_PORTS-1:0]                  s_axis_tlast,
    output logic [NUM_PORTS-1:0]                  s_axis_tready,

    output logic [AXIS_DATA_WIDTH-1:0]            m_axis_tdata,
    output logic [KEEP_W-1:0]                     m_axis_tkeep,
    output logic [AXIS_TUSER_WIDTH-1:0]           m_axis_tuser,
    output logic                                  m_axis_tvalid,
    output logic                                  m_axis_tlast,
    input  logic                                  m_axis_tready,
    output logic [SEL_W-1:0]                      m_axis_tsrc
);

    arb_state_t             state_reg, state_next;
    logic [SEL_W-1:0]       grant_reg, grant_next;
    logic [SEL_W-1:0]       last_grant_reg, last_grant_next;

    logic [SEL_W-1:0]       pick_winner;
    logic                   pick_any;

    logic                   out_free;
    logic                   accept;
    logic                   accept_last;

    logic [AXIS_DATA_WIDTH-1:0]  m_tdata_reg;
    logic [KEEP_W-1:0]           m_tkeep_reg;
    logic [AXIS_TUSER_WIDTH-1:0] m_tuser_reg;
    logic                        m_tvalid_reg;
    logic                        m_tlast_reg;
    logic [SEL_W-1:0]            m_tsrc_reg;

    logic [AXIS_DATA_WIDTH-1:0]  port_tdata [NUM_PORTS];
    logic [KEEP_W-1:0]           port_tkeep [NUM_PORTS];
    logic [AXIS_TUSER_WIDTH-1:0] port_tuser [NUM_PORTS];

    // The output register can take a new beat when empty or when its current beat is leaving.
    assign out_free = !m_tvalid_reg || m_axis_tready;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PORTS; gi++) begin : g_port
            assign port_tdata[gi]    = s_axis_tdata[gi*AXIS_DATA_WIDTH +: AXIS_DATA_WIDTH];
            assign port_tkeep[gi]    = s_axis_tkeep[gi*KEEP_W +: KEEP_W];
            assign port_tuser[gi]    = s_axis_tuser[gi*AXIS_TUSER_WIDTH +: AXIS_TUSER_WIDTH];
            assign s_axis_tready[gi] = (state_reg == BUSY) && (grant_reg == SEL_W'(gi)) && out_free;
        end
    endgenerate

    assign accept      = s_axis_tvalid[grant_reg] && s_axis_tready[grant_reg];
    assign accept_last = accept && s_axis_tlast[grant_reg];

    axis_rr_pick #(
        .NUM_PORTS (NUM_PORTS),
        .SEL_W     (SEL_W)
    ) u_pick (
        .req        (s_axis_tvalid),
        .last_grant (last_grant_reg),
        .winner     (pick_winner),
        .any_req    (pick_any)
    );

    always_ff @(posedge axis_aclk or posedge axis_reset) begin
        if (axis_reset) begin
            state_reg      <= IDLE;
            grant_reg      <= '0;
            last_grant_reg <= SEL_W'(NUM_PORTS - 1);
        end else begin
            state_reg      <= state_next;
            grant_reg      <= grant_next;
            last_grant_reg <= last_grant_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        grant_next      = grant_reg;
        last_grant_next = last_grant_reg;
        case (state_reg)
            IDLE: begin
                if (pick_any) begin
                    grant_next = pick_winner;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                // Only the closing beat releases the grant; tvalid gaps just stall.
                if (accept_last) begin
                    last_grant_next = grant_reg;
                    state_next      = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge axis_aclk or posedge axis_reset) begin
        if (axis_reset) begin
            m_tdata_reg  <= '0;
            m_tkeep_reg  <= '0;
            m_tuser_reg  <= '0;
            m_tvalid_reg <= 1'b0;
            m_tlast_reg  <= 1'b0;
            m_tsrc_reg   <= '0;
        end else if (accept) begin
            m_tdata_reg  <= port_tdata[grant_reg];
            m_tkeep_reg  <= port_tkeep[grant_reg];
            m_tuser_reg  <= port_tuser[grant_reg];
            m_tvalid_reg <= 1'b1;
            m_tlast_reg  <= s_axis_tlast[grant_reg];
            m_tsrc_reg   <= grant_reg;
        end else if (out_free) begin
            m_tvalid_reg <= 1'b0;
        end
    end

    assign m_axis_tdata  = m_tdata_reg;
    assign m_axis_tkeep  = m_tkeep_reg;
    assign m_axis_tuser  = m_tuser_reg;
    assign m_axis_tvalid = m_tvalid_reg;
    assign m_axis_tlast  = m_tlast_reg;
    assign m_axis_tsrc   = m_tsrc_reg;

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Directed and randomized checks of axis_rr_arbiter against a packet-level reference model.
module tb_axis_rr_arbiter;

    localparam int DW = 32;
    localparam int UW = 8;
    localparam int N  = 4;
    localparam int KW = DW / 8;
    localparam int SW = $clog2(N);

    logic            axis_aclk;
    logic            axis_reset;
    logic [N*DW-1:0] s_axis_tdata;
    logic [N*KW-1:0] s_axis_tkeep;
    logic [N*UW-1:0] s_axis_tuser;
    logic [N-1:0]    s_axis_tvalid;
    logic [N-1:0]    s_axis_tlast;
    logic [N-1:0]    s_axis_tready;
    logic [DW-1:0]   m_axis_tdata;
    logic [KW-1:0]   m_axis_tkeep;
    logic [UW-1:0]   m_axis_tuser;
    logic            m_axis_tvalid;
    logic            m_axis_tlast;
    logic            m_axis_tready;
    logic [SW-1:0]   m_axis_tsrc;

    axis_rr_arbiter #(
        .AXIS_DATA_WIDTH  (DW),
        .AXIS_TUSER_WIDTH (UW),
        .NUM_PORTS        (N)
    ) dut (
        .axis_aclk     (axis_aclk),
        .axis_reset    (axis_reset),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tuser  (s_axis_tuser),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tready (m_axis_tready),
        .m_axis_tsrc   (m_axis_tsrc)
    );

    initial axis_aclk = 1'b0;
    always #5 axis_aclk = ~axis_aclk;

    typedef struct {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic [UW-1:0] user;
        logic          last;
    } beat_t;

    beat_t src_q [N][$];   // beats each source still has to offer
    beat_t exp_q [$];      // beats accepted by the arbiter, in output order
    int    log_src [$];    // source of every beat that left the master port
    int    log_cyc [$];

    int       checks = 0;
    int       errors = 0;
    int       cyc    = 0;
    logic [N-1:0] hold;

    // Reference model: which port owns the master stream (-1 = nobody), who owned it last,
    // and whether a beat is sitting on the master port.
    int owner;
    int last_owner;
    bit out_valid;
    int out_src;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic add_pkt(input int p, input int len);
        beat_t b;
        for (int i = 0; i < len; i++) begin
            b.data = $urandom;
            b.keep = KW'($urandom);
            b.user = UW'($urandom);
            b.last = (i == len - 1);
            src_q[p].push_back(b);
        end
    endtask

    task automatic drive_inputs();
        for (int p = 0; p < N; p++) begin
            if (src_q[p].size() > 0 && !hold[p]) begin
                s_axis_tvalid[p]          = 1'b1;
                s_axis_tdata[p*DW +: DW]  = src_q[p][0].data;
                s_axis_tkeep[p*KW +: KW]  = src_q[p][0].keep;
                s_axis_tuser[p*UW +: UW]  = src_q[p][0].user;
                s_axis_tlast[p]           = src_q[p][0].last;
            end else begin
                s_axis_tvalid[p]          = 1'b0;
                s_axis_tdata[p*DW +: DW]  = $urandom;
                s_axis_tkeep[p*KW +: KW]  = KW'($urandom);
                s_axis_tuser[p*UW +: UW]  = UW'($urandom);
                s_axis_tlast[p]           = 1'($urandom);
            end
        end
    endtask

    // One clock cycle: drive, compare at mid-cycle, advance the model, cross the edge.
    task automatic tick();
        logic [N-1:0] exp_rdy;
        bit           acc;
        beat_t        b;
        drive_inputs();
        #1;
        exp_rdy = '0;
        if (owner >= 0 && (!out_valid || m_axis_tready)) exp_rdy[owner] = 1'b1;
        chk("s_tready", s_axis_tready, exp_rdy);
        chk("m_tvalid", m_axis_tvalid, out_valid);
        if (out_valid) begin
            chk("m_tsrc", m_axis_tsrc, out_src);
            chk("sb_depth", exp_q.size(), 1);
            if (exp_q.size() > 0) begin
                chk("m_tdata", m_axis_tdata, exp_q[0].data);
                chk("m_tkeep", m_axis_tkeep, exp_q[0].keep);
                chk("m_tuser", m_axis_tuser, exp_q[0].user);
                chk("m_tlast", m_axis_tlast, exp_q[0].last);
            end
        end
        if (out_valid && m_axis_tready) begin
            log_src.push_back(out_src);
            log_cyc.push_back(cyc);
            if (exp_q.size() > 0) void'(exp_q.pop_front());
        end
        acc = (owner >= 0) && s_axis_tvalid[owner] && exp_rdy[owner];
        if (acc) begin
            b = src_q[owner].pop_front();
            exp_q.push_back(b);
            out_valid = 1'b1;
            out_src   = owner;
            if (b.last) begin
                last_owner = owner;
                owner      = -1;
            end
        end else begin
            if (!out_valid || m_axis_tready) out_valid = 1'b0;
            if (owner < 0) begin
                for (int k = N; k >= 1; k--) begin
                    if (s_axis_tvalid[(last_owner + k) % N]) owner = (last_owner + k) % N;
                end
            end
        end
        @(posedge axis_aclk);
        @(negedge axis_aclk);
        cyc++;
    endtask

    task automatic do_reset();
        axis_reset = 1'b1;
        #1;
        chk("rst_m_tvalid", m_axis_tvalid, 1'b0);
        chk("rst_m_tlast",  m_axis_tlast, 1'b0);
        chk("rst_m_tdata",  m_axis_tdata, '0);
        chk("rst_m_tkeep",  m_axis_tkeep, '0);
        chk("rst_m_tuser",  m_axis_tuser, '0);
        chk("rst_m_tsrc",   m_axis_tsrc, '0);
        chk("rst_s_tready", s_axis_tready, '0);
        for (int p = 0; p < N; p++) src_q[p].delete();
        exp_q.delete();
        log_src.delete();
        log_cyc.delete();
        hold          = '0;
        s_axis_tvalid = '0;
        owner         = -1;
        last_owner    = N - 1;
        out_valid     = 1'b0;
        out_src       = 0;
        @(posedge axis_aclk);
        @(negedge axis_aclk);
        axis_reset = 1'b0;
    endtask

    function automatic bit pending();
        bit any;
        any = out_valid || (owner >= 0);
        for (int p = 0; p < N; p++) if (src_q[p].size() > 0) any = 1'b1;
        return any;
    endfunction

    initial begin
        int budget;
        int snap_data;
        axis_reset    = 1'b1;
        m_axis_tready = 1'b1;
        hold          = '0;
        s_axis_tvalid = '0;
        s_axis_tlast  = '0;
        s_axis_tdata  = '0;
        s_axis_tkeep  = '0;
        s_axis_tuser  = '0;
        @(negedge axis_aclk);
        do_reset();

        // Two 3-beat packets: port 0 back-to-back, one idle cycle, then port 2.
        add_pkt(0, 3);
        add_pkt(2, 3);
        budget = 0;
        while (log_src.size() < 6 && budget < 40) begin tick(); budget++; end
        chk("p02_count", log_src.size(), 6);
        if (log_src.size() == 6) begin
            for (int i = 0; i < 6; i++) chk($sformatf("p02_src%0d", i), log_src[i], (i < 3) ? 0 : 2);
            chk("p02_back2back0", log_cyc[1] - log_cyc[0], 1);
            chk("p02_back2back1", log_cyc[2] - log_cyc[1], 1);
            chk("p02_idle_gap",   log_cyc[3] - log_cyc[2], 2);
        end

        // Every port streaming single-beat packets rotates 0,1,2,3 with a gap after each.
        do_reset();
        for (int r = 0; r < 2; r++) for (int p = 0; p < N; p++) add_pkt(p, 1);
        budget = 0;
        while (log_src.size() < 8 && budget < 40) begin tick(); budget++; end
        chk("rot_count", log_src.size(), 8);
        if (log_src.size() == 8) begin
            for (int i = 0; i < 8; i++) chk($sformatf("rot_src%0d", i), log_src[i], i % N);
            for (int i = 1; i < 8; i++) chk($sformatf("rot_gap%0d", i), log_cyc[i] - log_cyc[i-1], 2);
        end

        // Port 1 four-beat packet with the master stalled while beat 2 is presented.
        log_src.delete(); log_cyc.delete();
        add_pkt(1, 4);
        budget = 0;
        while (!(log_src.size() == 1 && out_valid) && budget < 20) begin tick(); budget++; end
        chk("stall_reached", log_src.size(), 1);
        m_axis_tready = 1'b0;
        snap_data = int'(m_axis_tdata);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_hold_data", m_axis_tdata, snap_data);
            chk("stall_p1_rdy", s_axis_tready[1], 1'b0);
        end
        m_axis_tready = 1'b1;
        budget = 0;
        while (log_src.size() < 4 && budget < 20) begin tick(); budget++; end
        chk("stall_count", log_src.size(), 4);
        if (log_src.size() == 4) for (int i = 0; i < 4; i++) chk($sformatf("stall_src%0d", i), log_src[i], 1);

        // Port 3 pauses mid-packet; port 0 waits behind it.
        log_src.delete(); log_cyc.delete();
        add_pkt(3, 4);
        budget = 0;
        while (owner != 3 && budget < 10) begin tick(); budget++; end
        chk("gap_owner", owner, 3);
        add_pkt(0, 1);
        budget = 0;
        while (src_q[3].size() > 2 && budget < 10) begin tick(); budget++; end
        chk("gap_left", src_q[3].size(), 2);
        hold[3] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("gap_p0_rdy", s_axis_tready[0], 1'b0);
        end
        hold[3] = 1'b0;
        budget = 0;
        while (log_src.size() < 5 && budget < 20) begin tick(); budget++; end
        chk("gap_count", log_src.size(), 5);
        if (log_src.size() == 5) begin
            chk("gap_p3_tail", log_src[3], 3);
            chk("gap_p0_after", log_src[4], 0);
        end

        // Reset lands while beat 2 of a port-2 packet sits on the output.
        log_src.delete(); log_cyc.delete();
        add_pkt(2, 4);
        budget = 0;
        while (!(log_src.size() == 1 && out_valid) && budget < 20) begin tick(); budget++; end
        chk("mid_rst_reached", m_axis_tvalid, 1'b1);
        do_reset();
        add_pkt(1, 2);
        add_pkt(2, 2);
        budget = 0;
        while (log_src.size() < 4 && budget < 20) begin tick(); budget++; end
        chk("post_rst_count", log_src.size(), 4);
        if (log_src.size() == 4) begin
            chk("post_rst_first", log_src[0], 1);
            chk("post_rst_third", log_src[2], 2);
        end

        // Randomized traffic, source gaps and master back-pressure.
        for (int c = 0; c < 600; c++) begin
            for (int p = 0; p < N; p++) begin
                if ($urandom_range(0, 5) == 0 && src_q[p].size() < 8) add_pkt(p, $urandom_range(1, 5));
                hold[p] = ($urandom_range(0, 3) == 0);
            end
            m_axis_tready = ($urandom_range(0, 3) != 0);
            tick();
        end
        hold = '0;
        m_axis_tready = 1'b1;
        budget = 0;
        while (pending() && budget < 600) begin tick(); budget++; end
        chk("drain_done", pending(), 1'b0);
        chk("drain_sb_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
